// File: rtl/noc_uart_rx.sv
// UART 8N1 receiver: synchronises the raw pin, deserialises frames and
// presents bytes on a valid/ready handshake with sticky framing/overrun flags.
`timescale 1ns/1ps

module noc_uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_err_o,
  input  logic       err_clr_i
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_err_q, overrun_err_d;

  logic stop_sample, byte_done, frame_evt, handshake;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], uart_rx};
  assign rxs    = sync_q[SYNC_STAGES-1];

  // Sync chain resets to the idle-high line level so reset never fakes a start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '1;
      state_q <= ST_IDLE;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d            = '0;
          shreg_d[bit_idx_q] = rxs;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = rxs ? ST_IDLE : ST_BREAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stop_sample = (state_q == ST_STOP) && (cnt_q == BIT_M1);
  assign byte_done   = stop_sample && rxs;
  assign frame_evt   = stop_sample && !rxs;
  assign handshake   = rx_valid_q && rx_ready_i;

  // A delivery may reuse the output register in the same cycle it is consumed.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = frame_err_q;
    overrun_err_d = overrun_err_q;
    if (err_clr_i) begin
      frame_err_d   = 1'b0;
      overrun_err_d = 1'b0;
    end
    if (handshake) rx_valid_d = 1'b0;
    if (byte_done) begin
      if (!rx_valid_q || handshake) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
    if (frame_evt) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shreg_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign frame_err_o   = frame_err_q;
  assign overrun_err_o = overrun_err_q;

endmodule

// File: tb/tb_noc_uart_rx.sv
// Scoreboard bench for noc_uart_rx: directed frames push expected bytes,
// a monitor pops and compares on every handshake.
`timescale 1ns/1ps

module tb_noc_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       uart_rx;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       overrun_err_o;
  logic       err_clr_i;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  noc_uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .uart_rx      (uart_rx),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_err_o(overrun_err_o),
    .err_clr_i    (err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_val);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_val;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic stop_val,
                                input logic expect_byte);
    if (expect_byte) exp_q.push_back(d);
    send_frame(d, stop_val);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready_i = v;
    @(negedge clk);
  endtask

  task automatic pulse_err_clr();
    @(posedge clk);
    #1 err_clr_i = 1'b1;
    @(posedge clk);
    #1 err_clr_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rstn && rx_valid_o && rx_ready_i) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data_o);
      end else begin
        check_output("rx_byte", {24'h0, rx_data_o}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    rstn = 1'b0;
    uart_rx = 1'b1;
    rx_ready_i = 1'b0;
    err_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_data", {24'h0, rx_data_o}, 32'h0);
    check_output("reset_valid", {31'h0, rx_valid_o}, 32'h0);
    check_output("reset_frame_err", {31'h0, frame_err_o}, 32'h0);
    check_output("reset_overrun", {31'h0, overrun_err_o}, 32'h0);
    rstn = 1'b1;
    idle_bits(1);

    // Single frame with latency measurement.
    set_ready(1'b1);
    lat = -1;
    fork
      apply_stimulus(8'hA5, 1'b1, 1'b1);
      begin
        for (int n = 0; n < 400; n++) begin
          @(posedge clk);
          #1;
          if (rx_valid_o) begin
            lat = n;
            break;
          end
        end
      end
    join
    tests_run++;
    if (lat < SYNC + 1 + CPB / 2 + 9 * CPB - 1 || lat > SYNC + 1 + CPB / 2 + 9 * CPB + 1) begin
      tests_failed++;
      $display("[TB] FAIL valid_latency: got %0d cycles, expected %0d +-1",
               lat, SYNC + 1 + CPB / 2 + 9 * CPB);
    end
    idle_bits(1);
    check_output("a5_frame_err", {31'h0, frame_err_o}, 32'h0);
    check_output("a5_overrun", {31'h0, overrun_err_o}, 32'h0);

    // Short glitch must be rejected as a false start.
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    idle_bits(3);
    check_output("glitch_valid", {31'h0, rx_valid_o}, 32'h0);
    check_output("glitch_frame_err", {31'h0, frame_err_o}, 32'h0);
    check_output("glitch_overrun", {31'h0, overrun_err_o}, 32'h0);

    // Framing error, recovery, then clear.
    apply_stimulus(8'h3C, 1'b0, 1'b0);
    idle_bits(1);
    check_output("fe_frame_err", {31'h0, frame_err_o}, 32'h1);
    check_output("fe_valid", {31'h0, rx_valid_o}, 32'h0);
    apply_stimulus(8'h5A, 1'b1, 1'b1);
    idle_bits(1);
    check_output("fe_sticky", {31'h0, frame_err_o}, 32'h1);
    pulse_err_clr();
    check_output("fe_cleared", {31'h0, frame_err_o}, 32'h0);

    // Overrun: second byte dropped while first is held.
    set_ready(1'b0);
    apply_stimulus(8'h11, 1'b1, 1'b1);
    idle_bits(1);
    apply_stimulus(8'h22, 1'b1, 1'b0);
    idle_bits(1);
    check_output("ovr_data_held", {24'h0, rx_data_o}, 32'h11);
    check_output("ovr_valid", {31'h0, rx_valid_o}, 32'h1);
    check_output("ovr_flag", {31'h0, overrun_err_o}, 32'h1);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check_output("ovr_drained", {31'h0, rx_valid_o}, 32'h0);
    idle_bits(1);

    // Reset during data bit 4; held until the line is idle again.
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (CPB + 4 * CPB + CPB / 2) @(negedge clk);
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_output("midrst_data", {24'h0, rx_data_o}, 32'h0);
        check_output("midrst_valid", {31'h0, rx_valid_o}, 32'h0);
        check_output("midrst_frame_err", {31'h0, frame_err_o}, 32'h0);
        check_output("midrst_overrun", {31'h0, overrun_err_o}, 32'h0);
      end
    join
    @(negedge clk);
    rstn = 1'b1;
    idle_bits(2);
    check_output("postrst_valid", {31'h0, rx_valid_o}, 32'h0);
    apply_stimulus(8'hC3, 1'b1, 1'b1);
    idle_bits(2);

    // Ten back-to-back frames.
    for (int i = 0; i < 10; i++) apply_stimulus(8'(i), 1'b1, 1'b1);
    idle_bits(2);
    check_output("b2b_frame_err", {31'h0, frame_err_o}, 32'h0);
    check_output("b2b_overrun", {31'h0, overrun_err_o}, 32'h0);
    check_output("scoreboard_empty", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/noc_uart_rx.md
# noc_uart_rx

UART receive front-end for the FPGA NoC traffic-generator bench. It takes the raw board `uart_rx` pin and deserialises 8N1 frames into bytes. It presents each byte on a valid/ready handshake to the generator's command/control logic. It sits directly upstream of `gen` on the host-to-board path, replacing direct pin handling inside the generator, and reports framing and overrun errors that feed the `uart_err` indicator.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 8 and even; `HALF = CLKS_PER_BIT/2`.
- `SYNC_STAGES`, default 2: metastability flops on `uart_rx`. Must be ≥ 2.
- `clk`  in  1  system clock, the single clock of the block.
- `rstn`  in  1  reset, asynchronous, active-low; all state clears on assertion.
- `uart_rx`  in  1  raw serial line, asynchronous to `clk`, idle high.
- `rx_data_o`  out  8  received byte, LSB = first data bit.
- `rx_valid_o`  out  1  `rx_data_o` holds an unconsumed byte.
- `rx_ready_i`  in  1  consumer accepts the byte on a clock edge where `rx_valid_o` is also high.
- `frame_err_o`  out  1  sticky: a stop bit was sampled low.
- `overrun_err_o`  out  1  sticky: a byte was dropped because the output register was full.
- `err_clr_i`  in  1  single-cycle pulse that clears both sticky flags.

## Operation
- `uart_rx` passes through `SYNC_STAGES` flops. The last flop output is `rxs`, and no other logic reads the pin. Sync flops reset to 1.
- State machine states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxs`==0, go to START and set cnt=0.
  - START: cnt increments. At cnt==HALF-1, sample `rxs`. If 0, go to DATA with cnt=0 and bit_idx=0. If 1, this is a false start: return to IDLE.
  - DATA: cnt counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, shift `rxs` into shreg[bit_idx] and set cnt=0. After bit_idx 7, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample `rxs`.
    - If 1: deliver the byte and return to IDLE.
    - If 0: set `frame_err_o`, discard the byte and go to BREAK.
  - BREAK: wait for `rxs`==1, then go to IDLE. This means a held-low line yields exactly one frame error and no bytes.
- Delivery:
  - If `rx_valid_o`==0, or a handshake occurs in the same cycle: load `rx_data_o` and set `rx_valid_o`=1.
  - Otherwise, set `overrun_err_o`, drop the new byte and keep the old byte unchanged.
- Handshake: `rx_valid_o` stays high and `rx_data_o` stays stable until an edge with `rx_ready_i`==1. With no new delivery on that edge, `rx_valid_o` falls to 0 on it.
- Simultaneous handshake and delivery: the new byte loads, `rx_valid_o` stays 1, and no overrun is flagged.
- Simultaneous `err_clr_i` and an error event: the set wins, and the flag stays 1.
- Counters are sized `$clog2(CLKS_PER_BIT)` bits and never wrap past CLKS_PER_BIT-1.
- Reset values:
  - All outputs: `rx_data_o`=8'h00, `rx_valid_o`=0, `frame_err_o`=0, `overrun_err_o`=0.
  - Internal: state=IDLE, cnt=0, bit_idx=0, shreg=0.
- Reset mid-frame aborts the frame with no delivery and no error. After release, if the line is low, the next falling level is treated as a start.

## Timing
- Input latency: `SYNC_STAGES` cycles from pin to `rxs`.
- Sample points: mid-bit, at HALF + k·CLKS_PER_BIT cycles after START entry, where k=1..8 for data and k=9 for stop.
- Byte latency: `rx_valid_o` rises SYNC_STAGES + 1 + HALF + 9·CLKS_PER_BIT cycles after the first clock edge that samples the pin low. Bench tolerance is ±1 cycle.
- `frame_err_o` rises at the same cycle offset as `rx_valid_o` would have.
- Back-to-back frames are supported. The block is in IDLE by mid-stop-bit, so a start bit following the stop bit is caught.
- The consumer has ≥ 9.5 bit times to accept a byte before an overrun can occur.
- All outputs are registered, with no combinational path from input to output.

## Test plan
- CLKS_PER_BIT=16, one frame 0xA5 with `rx_ready_i`=1:
  - `rx_data_o`=8'hA5 and `rx_valid_o` high for exactly 1 cycle.
  - The valid pulse lands at cycle SYNC_STAGES+1+8+144 ±1 after the start edge.
  - No error flags set.
- 4-cycle low glitch on the idle line -> no `rx_valid_o` and no errors; the FSM returns to IDLE.
- Frame 0x3C with stop bit driven low for 1 bit time:
  - `frame_err_o`=1, no `rx_valid_o`.
  - A following valid 0x5A is received correctly.
  - An `err_clr_i` pulse then clears `frame_err_o`.
- Frames 0x11 then 0x22 with `rx_ready_i`=0:
  - `rx_data_o` stays 8'h11 and `overrun_err_o`=1.
  - Raising ready consumes 0x11; 0x22 is never presented.
- `rstn` pulsed low during data bit 4 of 0x77:
  - All outputs return to reset values, and no byte or error is produced.
  - The next clean frame 0xC3 is received.
- Ten back-to-back frames 0x00..0x09 with `rx_ready_i`=1 -> all ten bytes are received in order with no errors.
